// File: rtl/dm_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dm_pkg
//  Description : Types and constants shared between the DM pipeline stage
//                and the memory-side responder.
//                Holds the load/store opcode encodings, the opcode width,
//                the wait-counter width and the responder state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int OPC_W = 4;
    localparam int CNT_W = 4;

    localparam logic [OPC_W-1:0] OPC_LOAD  = 4'b1101;
    localparam logic [OPC_W-1:0] OPC_STORE = 4'b1110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dm_rsp_state_t;

    // True for the two opcodes that touch the data RAM.
    function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_mem_responder_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dm_ram_sp
//  Description : Single-port data RAM, 2**ADDR_W words of DATA_W bits.
//                Synchronous write, synchronous read; contents are not reset.
//  Ports       : clk   - clock, rising edge
//                en    - access enable
//                we    - write enable (qualified by en)
//                addr  - word address
//                wdata - write data
//                rdata - read data, updated the edge after a read access
//                        and held until the next read
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_ram_sp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dm_mem_responder
//  Description : Memory-side end of the DM stage interface. Accepts one
//                load/store/no-op request at a time, waits WAIT_CYCLES,
//                performs the RAM access and returns a response over a
//                valid/ready handshake.
//  Ports       : clk, rst_n               - clock / async active-low reset
//                req_valid/req_ready      - request handshake
//                req_opcode/addr/wdata    - request payload
//                rsp_valid/rsp_ready      - response handshake
//                rsp_rdata                - load data (0 for store / no-op)
//                rsp_is_load, rsp_noop    - response kind
//                busy                     - high whenever not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_mem_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OPC_W-1:0]  req_opcode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_is_load,
    output logic              rsp_noop,
    output logic              busy
);

    // The wait counter is 4 bits wide, so larger values cannot be honoured.
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range_check
        $error("dm_mem_responder: WAIT_CYCLES must be in 0..15");
    end

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    dm_rsp_state_t     state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              rsp_valid_nxt, rsp_is_load_nxt, rsp_noop_nxt;
    logic              accept;

    logic [OPC_W-1:0]  opc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              ram_en, ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // ------------------------------------------------------------------
    // State, counter, response flags and request latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_is_load <= 1'b0;
            rsp_noop    <= 1'b0;
            opc_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_is_load <= rsp_is_load_nxt;
            rsp_noop    <= rsp_noop_nxt;
            if (accept) begin
                opc_q   <= req_opcode;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        rsp_valid_nxt   = rsp_valid;
        rsp_is_load_nxt = rsp_is_load;
        rsp_noop_nxt    = rsp_noop;
        accept          = 1'b0;
        ram_en          = 1'b0;
        ram_we          = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (is_mem_op(req_opcode)) begin
                        if (WAIT_CYCLES == 0) begin
                            state_nxt = ACCESS;
                        end else begin
                            state_nxt = WAIT;
                            cnt_nxt   = WAIT_INIT;
                        end
                    end else begin
                        // Non-memory opcode: answer immediately, RAM untouched.
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_noop_nxt  = 1'b1;
                    end
                end
            end

            WAIT: begin
                cnt_nxt = cnt - 1'b1;
                // The <= guard also rescues a counter that is somehow at 0.
                if (cnt <= 1) begin
                    state_nxt = ACCESS;
                end
            end

            ACCESS: begin
                // The store lands here, before its response is issued, which
                // is what makes a following load to the same address see it.
                ram_en          = 1'b1;
                ram_we          = (opc_q == OPC_STORE);
                state_nxt       = RESP;
                rsp_valid_nxt   = 1'b1;
                rsp_is_load_nxt = (opc_q == OPC_LOAD);
            end

            RESP: begin
                if (rsp_ready) begin
                    state_nxt       = IDLE;
                    rsp_valid_nxt   = 1'b0;
                    rsp_is_load_nxt = 1'b0;
                    rsp_noop_nxt    = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    dm_ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // The RAM output register holds the load data through RESP because the
    // RAM is not enabled again until the next request reaches ACCESS.
    assign rsp_rdata = rsp_is_load ? ram_rdata : '0;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dm_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_mem_responder
//  Description : Self-checking bench for dm_mem_responder. Two instances
//                (WAIT_CYCLES = 2 and 0) share the same stimulus; directed
//                vectors and random traffic are checked against a simple
//                memory model and the latency formula.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_mem_responder;

    localparam int W_A = 2;
    localparam int W_B = 0;

    logic       clk, rst_n;
    logic       req_valid, rsp_ready;
    logic [3:0] req_opcode;
    logic [7:0] req_addr, req_wdata;

    logic       a_req_ready, a_rsp_valid, a_rsp_is_load, a_rsp_noop, a_busy;
    logic [7:0] a_rsp_rdata;
    logic       b_req_ready, b_rsp_valid, b_rsp_is_load, b_rsp_noop, b_busy;
    logic [7:0] b_rsp_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] ref_mem [256];

    dm_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_is_load(a_rsp_is_load), .rsp_noop(a_rsp_noop), .busy(a_busy)
    );

    dm_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_is_load(b_rsp_is_load), .rsp_noop(b_rsp_noop), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Idle/cleared view of an instance: {valid, rdata, is_load, noop, req_ready, busy}
    function automatic logic [31:0] view_a();
        return 32'({a_rsp_valid, a_rsp_rdata, a_rsp_is_load, a_rsp_noop, a_req_ready, a_busy});
    endfunction
    function automatic logic [31:0] view_b();
        return 32'({b_rsp_valid, b_rsp_rdata, b_rsp_is_load, b_rsp_noop, b_req_ready, b_busy});
    endfunction
    localparam logic [31:0] IDLE_VIEW = 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});

    // One complete transaction, called and returning at a negedge.
    // While the response is held off, a conflicting store is presented and
    // must be ignored.
    task automatic transact(input logic [3:0] opc, input logic [7:0] addr,
                            input logic [7:0] wdata, input int hold,
                            input logic [7:0] exp_rd);
        bit         mem_op, ld;
        int         seen_a, seen_b, acc, n, lat_a, lat_b;
        logic [7:0] exp_data;
        mem_op   = (opc == 4'hD) || (opc == 4'hE);
        ld       = (opc == 4'hD);
        exp_data = ld ? exp_rd : 8'h00;
        lat_a    = mem_op ? W_A + 2 : 1;
        lat_b    = mem_op ? W_B + 2 : 1;
        seen_a   = -1;
        seen_b   = -1;

        n = 0;
        while (!(a_req_ready === 1'b1 && b_req_ready === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("req_ready_timeout", 32'(a_req_ready & b_req_ready), 32'd1);
            return;
        end

        req_opcode = opc;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(negedge clk);
        acc        = cyc;
        req_valid  = 1'b0;
        req_opcode = 4'($urandom);
        req_addr   = 8'($urandom);
        req_wdata  = 8'($urandom);

        n = 0;
        while ((seen_a < 0 || seen_b < 0) && n < 40) begin
            if (seen_a < 0 && a_rsp_valid === 1'b1) seen_a = cyc;
            if (seen_b < 0 && b_rsp_valid === 1'b1) seen_b = cyc;
            if (seen_a < 0 || seen_b < 0) begin
                @(negedge clk);
                n++;
            end
        end
        chk("latency_w2", 32'(seen_a + 1 - acc), 32'(lat_a));
        chk("latency_w0", 32'(seen_b + 1 - acc), 32'(lat_b));
        chk("rsp_a", 32'({a_rsp_valid, a_rsp_rdata, a_rsp_is_load, a_rsp_noop}),
            32'({1'b1, exp_data, ld, ~mem_op}));
        chk("rsp_b", 32'({b_rsp_valid, b_rsp_rdata, b_rsp_is_load, b_rsp_noop}),
            32'({1'b1, exp_data, ld, ~mem_op}));

        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                req_opcode = 4'hE;
                req_addr   = addr;
                req_wdata  = ~wdata;
                req_valid  = 1'b1;
            end
            @(negedge clk);
            chk("hold_a", 32'({a_rsp_valid, a_rsp_rdata, a_req_ready, a_busy}),
                32'({1'b1, exp_data, 1'b0, 1'b1}));
            chk("hold_b", 32'({b_rsp_valid, b_rsp_rdata, b_req_ready, b_busy}),
                32'({1'b1, exp_data, 1'b0, 1'b1}));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_hs_a", view_a(), IDLE_VIEW);
        chk("after_hs_b", view_b(), IDLE_VIEW);
    endtask

    typedef struct {
        logic [3:0] opc;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         hold;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [3:0] o;
        logic [7:0] ad, wd;
        int         kind;

        tbl[0]  = '{4'hE, 8'h01, 8'hA9, 0, 8'h00};
        tbl[1]  = '{4'hE, 8'h02, 8'h19, 1, 8'h00};
        tbl[2]  = '{4'hE, 8'h03, 8'h5D, 0, 8'h00};
        tbl[3]  = '{4'hE, 8'h01, 8'h40, 2, 8'h00};
        tbl[4]  = '{4'hD, 8'h01, 8'h00, 0, 8'h40};
        tbl[5]  = '{4'hD, 8'h02, 8'h00, 5, 8'h19};
        tbl[6]  = '{4'hD, 8'h03, 8'h00, 0, 8'h5D};
        tbl[7]  = '{4'hE, 8'h83, 8'h3C, 0, 8'h00};
        tbl[8]  = '{4'h9, 8'h83, 8'hAA, 0, 8'h00};
        tbl[9]  = '{4'h8, 8'h83, 8'h55, 1, 8'h00};
        tbl[10] = '{4'hD, 8'h83, 8'h00, 0, 8'h3C};
        tbl[11] = '{4'hE, 8'h00, 8'h77, 0, 8'h00};
        tbl[12] = '{4'hE, 8'hFF, 8'hFF, 0, 8'h00};
        tbl[13] = '{4'hD, 8'hFF, 8'h00, 0, 8'hFF};
        tbl[14] = '{4'hD, 8'h00, 8'h00, 3, 8'h77};
        tbl[15] = '{4'hD, 8'h02, 8'h00, 0, 8'h19};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        req_opcode = 4'h0;
        req_addr   = 8'h00;
        req_wdata  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_a", view_a(), IDLE_VIEW);
        chk("reset_b", view_b(), IDLE_VIEW);
        rst_n = 1'b1;
        @(negedge clk);

        // Give every RAM word a known value.
        for (int a = 0; a < 256; a++) begin
            ref_mem[a] = 8'($urandom);
            transact(4'hE, 8'(a), ref_mem[a], 0, 8'h00);
        end

        // rsp_ready held high while idle must not produce a response.
        rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_rsp_ready_a", view_a(), IDLE_VIEW);
            chk("idle_rsp_ready_b", view_b(), IDLE_VIEW);
        end
        rsp_ready = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            transact(tbl[i].opc, tbl[i].addr, tbl[i].wdata, tbl[i].hold, tbl[i].exp_rd);
            if (tbl[i].opc == 4'hE) ref_mem[tbl[i].addr] = tbl[i].wdata;
        end

        // Reset while a store is still waiting: it must be dropped.
        req_opcode = 4'hE;
        req_addr   = 8'h55;
        req_wdata  = ~ref_mem[8'h55];
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("in_wait_busy", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midwait_reset_a", view_a(), IDLE_VIEW);
        chk("midwait_reset_b", view_b(), IDLE_VIEW);
        @(negedge clk);
        chk("midwait_reset_next_a", view_a(), IDLE_VIEW);
        rst_n = 1'b1;
        @(negedge clk);
        transact(4'hD, 8'h55, 8'h00, 0, ref_mem[8'h55]);

        // Random traffic against the memory model.
        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 3));
            ad   = 8'($urandom);
            wd   = 8'($urandom);
            if (kind <= 1) begin
                o = 4'hD;
            end else if (kind == 2) begin
                o = 4'hE;
            end else begin
                o = 4'($urandom);
                while (o == 4'hD || o == 4'hE) o = 4'($urandom);
            end
            transact(o, ad, wd, int'($urandom_range(0, 3)), ref_mem[ad]);
            if (o == 4'hE) ref_mem[ad] = wd;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
